// File: rtl/flappy_motion_ctrl.sv
// Bird motion and game-state controller for the flappy game.
// Consumes PS2 space-key events over a registered ack handshake, runs tick-based
// bird physics (gravity, flap impulse, terminal velocity, ceiling/floor bounds),
// counts score from pipe-pass pulses and sequences an IDLE/RUN/DEAD game FSM.
//
// Ports:
//   clock       system clock, all state changes on posedge
//   reset       asynchronous active-high reset
//   key_state   PS2 event: 0 none, 1 press, 2 release, 3 ignored but acked
//   key_ack     registered one-cycle ack; source clears key_state on it
//   score_inc   one-cycle pipe-passed pulse
//   collide     pipe collision level
//   bird_y      bird Y (grows downward)
//   bird_v      signed bird velocity
//   score       saturating score
//   game_state  0 IDLE, 1 RUN, 2 DEAD
//   tick        physics tick strobe, one pulse every TICK_DIV cycles
//   leds        [0] key held, [1] RUN, [2] DEAD, [7:3] zero
module flappy_motion_ctrl #(
  parameter int unsigned Y_WIDTH     = 10,
  parameter int unsigned Y_MAX       = 456,
  parameter int unsigned Y_START     = 240,
  parameter int unsigned V_WIDTH     = 8,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned FLAP_SPEED  = 8,
  parameter int unsigned V_MAX       = 12,
  parameter int unsigned SCORE_WIDTH = 16,
  parameter int unsigned TICK_DIV    = 833333
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                key_state,
  output logic                      key_ack,
  input  logic                      score_inc,
  input  logic                      collide,
  output logic [Y_WIDTH-1:0]        bird_y,
  output logic signed [V_WIDTH-1:0] bird_v,
  output logic [SCORE_WIDTH-1:0]    score,
  output logic [1:0]                game_state,
  output logic                      tick,
  output logic [7:0]                leds
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SumW = Y_WIDTH + 2;

  localparam logic [CntW-1:0]           CntLast = CntW'(TICK_DIV - 1);
  localparam logic [Y_WIDTH-1:0]        YStart  = Y_WIDTH'(Y_START);
  localparam logic [Y_WIDTH-1:0]        YFloor  = Y_WIDTH'(Y_MAX);
  localparam logic signed [SumW-1:0]    YMaxW   = SumW'(Y_MAX);
  localparam logic signed [SumW-1:0]    YZero   = '0;
  localparam logic signed [V_WIDTH-1:0] VFlap   = V_WIDTH'(0 - FLAP_SPEED);
  localparam logic signed [V_WIDTH:0]   GravW   = (V_WIDTH + 1)'(GRAVITY);
  localparam logic signed [V_WIDTH:0]   VMaxW   = (V_WIDTH + 1)'(V_MAX);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDead = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [Y_WIDTH-1:0]          y_q, y_d;
  logic signed [V_WIDTH-1:0]   v_q, v_d;
  logic [SCORE_WIDTH-1:0]      score_q, score_d;
  logic                        ack_q;
  logic                        held_q, held_d;
  logic [CntW-1:0]             cnt_q;
  logic                        tick_q;

  logic                        consume, press, release_evt, cnt_last, floor_hit;
  logic signed [SumW-1:0]      y_ext, v_ext, y_sum;
  logic signed [V_WIDTH:0]     v_sum;
  logic signed [V_WIDTH-1:0]   v_grav;

  assign cnt_last    = (cnt_q == CntLast);
  // While the ack is high no event is taken, so a held key re-triggers every 2 cycles.
  assign consume     = (key_state != 2'd0) && !ack_q;
  assign press       = consume && (key_state == 2'd1);
  assign release_evt = consume && (key_state == 2'd2);

  // Position update is done signed and two bits wider so ceiling overshoot shows as <= 0.
  assign y_ext  = $signed({2'b00, y_q});
  assign v_ext  = $signed({{(SumW - V_WIDTH){v_q[V_WIDTH-1]}}, v_q});
  assign y_sum  = y_ext + v_ext;
  assign v_sum  = $signed({v_q[V_WIDTH-1], v_q}) + GravW;
  assign v_grav = (v_sum > VMaxW) ? VMaxW[V_WIDTH-1:0] : v_sum[V_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    v_d       = v_q;
    score_d   = score_q;
    held_d    = held_q;
    floor_hit = 1'b0;

    if (press) begin
      held_d = 1'b1;
    end else if (release_evt) begin
      held_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StRun;
          score_d = '0;
          y_d     = YStart;
          v_d     = VFlap;
        end
      end
      StRun: begin
        // Collision wins over everything and freezes the bird where it is.
        if (collide) begin
          state_d = StDead;
        end else begin
          if (score_inc && (score_q != '1)) begin
            score_d = score_q + SCORE_WIDTH'(1);
          end
          if (tick_q) begin
            if (y_sum <= YZero) begin
              y_d = '0;
              v_d = '0;
            end else if (y_sum >= YMaxW) begin
              y_d       = YFloor;
              v_d       = '0;
              state_d   = StDead;
              floor_hit = 1'b1;
            end else begin
              y_d = y_sum[Y_WIDTH-1:0];
              v_d = v_grav;
            end
          end
          // A flap on a tick still moves with the old velocity, then overrides it.
          if (press && !floor_hit) begin
            v_d = VFlap;
          end
        end
      end
      StDead: begin
        if (press) begin
          state_d = StIdle;
          y_d     = YStart;
          v_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      y_q     <= YStart;
      v_q     <= '0;
      score_q <= '0;
      ack_q   <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      score_q <= score_d;
      ack_q   <= consume;
      held_q  <= held_d;
      cnt_q   <= cnt_last ? '0 : cnt_q + CntW'(1);
      tick_q  <= cnt_last;
    end
  end

  assign key_ack    = ack_q;
  assign bird_y     = y_q;
  assign bird_v     = v_q;
  assign score      = score_q;
  assign game_state = state_q;
  assign tick       = tick_q;
  assign leds       = {5'b0_0000, state_q == StDead, state_q == StRun, held_q};

endmodule

// File: tb/tb_flappy_motion_ctrl.sv
// Self-checking bench for flappy_motion_ctrl with TICK_DIV=4. A second instance with
// SCORE_WIDTH=4 shares all stimulus to exercise score saturation.
module tb_flappy_motion_ctrl;

  localparam int TD = 4;

  logic              clock     = 1'b0;
  logic              reset     = 1'b1;
  logic [1:0]        key_state = 2'd0;
  logic              score_inc = 1'b0;
  logic              collide   = 1'b0;

  logic              key_ack, tick;
  logic [9:0]        bird_y;
  logic signed [7:0] bird_v;
  logic [15:0]       score;
  logic [1:0]        game_state;
  logic [7:0]        leds;

  logic              key_ack4, tick4;
  logic [9:0]        bird_y4;
  logic signed [7:0] bird_v4;
  logic [3:0]        score4;
  logic [1:0]        game_state4;
  logic [7:0]        leds4;

  flappy_motion_ctrl #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .key_state(key_state), .key_ack(key_ack),
    .score_inc(score_inc), .collide(collide), .bird_y(bird_y), .bird_v(bird_v),
    .score(score), .game_state(game_state), .tick(tick), .leds(leds)
  );

  flappy_motion_ctrl #(.TICK_DIV(TD), .SCORE_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .key_state(key_state), .key_ack(key_ack4),
    .score_inc(score_inc), .collide(collide), .bird_y(bird_y4), .bird_v(bird_v4),
    .score(score4), .game_state(game_state4), .tick(tick4), .leds(leds4)
  );

  always #5 clock = ~clock;

  typedef struct {
    int y;
    int v;
    int st;
    int sc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   tick_ref = -1;
  // Reference bird/game model
  int   m_y = 240, m_v = 0, m_st = 0, m_sc = 0;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    while (tick !== 1'b1 && k < 2 * TD) begin
      step();
      k++;
    end
    n_checks++;
    if (tick !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_timeout: tick=%b required 1", tick);
    end else if (tick_ref < 0) begin
      tick_ref = cyc;
    end else begin
      n_checks++;
      if ((cyc - tick_ref) % TD != 0) begin
        n_fail++;
        $display("FAIL tick_phase: offset=%0d required multiple of %0d", cyc - tick_ref, TD);
      end
    end
  endtask

  task automatic press(input logic [1:0] k);
    key_state = k;
    step();
    n_checks++;
    if (key_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL key_ack_rise: key_ack=%b required 1", key_ack);
    end
    key_state = 2'd0;
    step();
    n_checks++;
    if (key_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL key_ack_fall: key_ack=%b required 0", key_ack);
    end
  endtask

  // Wait for tick edges, predict each physics step, compare, then optionally send a key.
  task automatic run_ticks(input int n, input logic [1:0] key, input logic inc);
    exp_t       e;
    int         ny;
    logic [3:0] e4;
    for (int i = 0; i < n; i++) begin
      wait_tick();
      if (m_st == 1) begin
        ny = m_y + m_v;
        if (ny <= 0) begin
          m_y = 0;
          m_v = 0;
        end else if (ny >= 456) begin
          m_y  = 456;
          m_v  = 0;
          m_st = 2;
        end else begin
          m_y = ny;
          m_v = (m_v + 1 > 12) ? 12 : m_v + 1;
        end
        if (inc) m_sc++;
      end
      sb_q.push_back('{m_y, m_v, m_st, m_sc});
      score_inc = inc;
      step();
      score_inc = 1'b0;
      e  = sb_q.pop_front();
      e4 = (e.sc > 15) ? 4'd15 : e.sc[3:0];
      n_checks++;
      if (bird_y !== e.y[9:0] || bird_v !== e.v[7:0] || game_state !== e.st[1:0] ||
          score !== e.sc[15:0]) begin
        n_fail++;
        $display("FAIL physics_tick: y=%0d v=%0d st=%0d sc=%0d required y=%0d v=%0d st=%0d sc=%0d",
                 bird_y, bird_v, game_state, score, e.y, e.v, e.st, e.sc);
      end
      n_checks++;
      if (bird_y4 !== e.y[9:0] || bird_v4 !== e.v[7:0] || game_state4 !== e.st[1:0] ||
          score4 !== e4) begin
        n_fail++;
        $display("FAIL physics_tick_w4: y=%0d v=%0d st=%0d sc=%0d required y=%0d v=%0d st=%0d sc=%0d",
                 bird_y4, bird_v4, game_state4, score4, e.y, e.v, e.st, e4);
      end
      n_checks++;
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL tick_width: tick=%b required 0", tick);
      end
      if (key != 2'd0) begin
        press(key);
        if (key == 2'd1 && m_st == 1) m_v = -8;
      end
    end
  endtask

  // Press from IDLE one cycle after a tick so no RUN tick slips past the model.
  task automatic start_game();
    wait_tick();
    step();
    press(2'd1);
    m_st = 1;
    m_y  = 240;
    m_v  = -8;
    m_sc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (bird_y !== 10'd240) begin n_fail++; $display("FAIL rst_y: %0d required 240", bird_y); end
    n_checks++;
    if (bird_v !== 8'sd0) begin n_fail++; $display("FAIL rst_v: %0d required 0", bird_v); end
    n_checks++;
    if (score !== 16'd0) begin n_fail++; $display("FAIL rst_score: %0d required 0", score); end
    n_checks++;
    if (game_state !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_state: %0d required 0", game_state);
    end
    n_checks++;
    if (key_ack !== 1'b0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ack_tick: ack=%b tick=%b required 0 0", key_ack, tick);
    end
    n_checks++;
    if (leds !== 8'h00) begin n_fail++; $display("FAIL rst_leds: %b required 0", leds); end
    reset    = 1'b0;
    tick_ref = -1;
  endtask

  task automatic test_handshake();
    logic exp_ack;
    key_state = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_ack = (i % 2 == 0);
      n_checks++;
      if (key_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL retrigger_%0d: key_ack=%b required %b", i, key_ack, exp_ack);
      end
    end
    key_state = 2'd0;
    step();
    n_checks++;
    if (key_ack !== 1'b0 || leds !== 8'h00 || game_state !== 2'd0) begin
      n_fail++;
      $display("FAIL retrigger_end: ack=%b leds=%b st=%0d required 0 0 0",
               key_ack, leds, game_state);
    end
  endtask

  task automatic test_idle_press();
    wait_tick();
    step();
    n_checks++;
    if (key_ack !== 1'b0) begin n_fail++; $display("FAIL pre_ack: %b required 0", key_ack); end
    key_state = 2'd1;
    step();
    n_checks++;
    if (key_ack !== 1'b1) begin n_fail++; $display("FAIL idle_ack: %b required 1", key_ack); end
    n_checks++;
    if (game_state !== 2'd1 || bird_v !== -8'sd8 || bird_y !== 10'd240 || score !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_press: st=%0d v=%0d y=%0d sc=%0d required 1 -8 240 0",
               game_state, bird_v, bird_y, score);
    end
    n_checks++;
    if (leds !== 8'b0000_0011) begin
      n_fail++;
      $display("FAIL idle_leds: %b required 00000011", leds);
    end
    key_state = 2'd0;
    step();
    n_checks++;
    if (key_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack_fall: %b required 0", key_ack); end
    m_st = 1;
    m_y  = 240;
    m_v  = -8;
    m_sc = 0;
  endtask

  task automatic test_ticks();
    int   ys[3];
    int   vs[3];
    int   prev;
    exp_t e;
    ys   = '{232, 225, 219};
    vs   = '{-7, -6, -5};
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      if (i > 0) begin
        n_checks++;
        if (cyc - prev != TD) begin
          n_fail++;
          $display("FAIL tick_period: %0d cycles required %0d", cyc - prev, TD);
        end
      end
      prev = cyc;
      sb_q.push_back('{ys[i], vs[i], 1, 0});
      step();
      e = sb_q.pop_front();
      n_checks++;
      if (bird_y !== e.y[9:0] || bird_v !== e.v[7:0] || game_state !== 2'd1) begin
        n_fail++;
        $display("FAIL gravity_%0d: y=%0d v=%0d st=%0d required y=%0d v=%0d st=1",
                 i, bird_y, bird_v, game_state, e.y, e.v);
      end
      if (i == 0) begin
        press(2'd2);
        n_checks++;
        if (leds !== 8'b0000_0010) begin
          n_fail++;
          $display("FAIL release_leds: %b required 00000010", leds);
        end
      end
    end
    m_y  = 219;
    m_v  = -5;
    m_st = 1;
  endtask

  task automatic test_floor();
    logic saw12;
    int   k;
    saw12 = 1'b0;
    k     = 0;
    while (m_st == 1 && k < 80) begin
      run_ticks(1, 2'd0, 1'b0);
      if (bird_v == 8'sd12) saw12 = 1'b1;
      k++;
    end
    n_checks++;
    if (saw12 !== 1'b1) begin n_fail++; $display("FAIL v_terminal: saw12=%b required 1", saw12); end
    n_checks++;
    if (bird_y !== 10'd456 || bird_v !== 8'sd0 || game_state !== 2'd2 || leds !== 8'b0000_0100) begin
      n_fail++;
      $display("FAIL floor_death: y=%0d v=%0d st=%0d leds=%b required 456 0 2 00000100",
               bird_y, bird_v, game_state, leds);
    end
    run_ticks(1, 2'd0, 1'b0);
    n_checks++;
    if (bird_y !== 10'd456) begin n_fail++; $display("FAIL dead_frozen: y=%0d required 456", bird_y); end
    press(2'd1);
    m_st = 0;
    m_y  = 240;
    m_v  = 0;
    n_checks++;
    if (game_state !== 2'd0 || bird_y !== 10'd240 || bird_v !== 8'sd0 || leds !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL dead_press: st=%0d y=%0d v=%0d leds=%b required 0 240 0 00000001",
               game_state, bird_y, bird_v, leds);
    end
    press(2'd2);
  endtask

  task automatic test_collide();
    exp_t e;
    start_game();
    run_ticks(3, 2'd0, 1'b1);
    n_checks++;
    if (score !== 16'd3) begin n_fail++; $display("FAIL score_three: %0d required 3", score); end
    m_st = 2;
    sb_q.push_back('{m_y, m_v, m_st, m_sc});
    collide   = 1'b1;
    score_inc = 1'b1;
    step();
    collide   = 1'b0;
    score_inc = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (bird_y !== e.y[9:0] || bird_v !== e.v[7:0] || game_state !== 2'd2 || score !== 16'd3) begin
      n_fail++;
      $display("FAIL collide: y=%0d v=%0d st=%0d sc=%0d required y=%0d v=%0d st=2 sc=3",
               bird_y, bird_v, game_state, score, e.y, e.v);
    end
    collide   = 1'b1;
    score_inc = 1'b1;
    step();
    step();
    collide   = 1'b0;
    score_inc = 1'b0;
    run_ticks(1, 2'd0, 1'b1);
    n_checks++;
    if (score !== 16'd3 || game_state !== 2'd2) begin
      n_fail++;
      $display("FAIL dead_score: sc=%0d st=%0d required 3 2", score, game_state);
    end
  endtask

  task automatic test_async_reset();
    press(2'd1);
    m_st = 0;
    m_y  = 240;
    m_v  = 0;
    start_game();
    run_ticks(5, 2'd0, 1'b1);
    run_ticks(3, 2'd0, 1'b0);
    press(2'd1);
    m_v = -8;
    run_ticks(13, 2'd1, 1'b0);
    n_checks++;
    if (bird_y !== 10'd100 || score !== 16'd5 || leds !== 8'b0000_0011) begin
      n_fail++;
      $display("FAIL pre_reset: y=%0d sc=%0d leds=%b required 100 5 00000011", bird_y, score, leds);
    end
    reset = 1'b1;
    #2;
    n_checks++;
    if (bird_y !== 10'd240 || bird_v !== 8'sd0 || score !== 16'd0 || game_state !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: y=%0d v=%0d sc=%0d st=%0d required 240 0 0 0",
               bird_y, bird_v, score, game_state);
    end
    n_checks++;
    if (leds !== 8'h00 || key_ack !== 1'b0 || score4 !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset_misc: leds=%b ack=%b sc4=%0d required 0 0 0", leds, key_ack, score4);
    end
    step();
    reset    = 1'b0;
    tick_ref = -1;
    m_st     = 0;
    m_y      = 240;
    m_v      = 0;
    m_sc     = 0;
  endtask

  task automatic test_ceiling();
    start_game();
    run_ticks(8, 2'd0, 1'b0);
    press(2'd1);
    m_v = -8;
    run_ticks(25, 2'd1, 1'b0);
    n_checks++;
    if (bird_y !== 10'd4 || bird_v !== -8'sd8 || game_state !== 2'd1) begin
      n_fail++;
      $display("FAIL pre_ceiling: y=%0d v=%0d st=%0d required 4 -8 1", bird_y, bird_v, game_state);
    end
    run_ticks(1, 2'd0, 1'b0);
    n_checks++;
    if (bird_y !== 10'd0 || bird_v !== 8'sd0 || game_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ceiling: y=%0d v=%0d st=%0d required 0 0 1", bird_y, bird_v, game_state);
    end
  endtask

  task automatic test_score_sat();
    score_inc = 1'b1;
    repeat (20) step();
    score_inc = 1'b0;
    m_sc = 20;
    n_checks++;
    if (score !== 16'd20) begin n_fail++; $display("FAIL score_20: %0d required 20", score); end
    n_checks++;
    if (score4 !== 4'd15) begin n_fail++; $display("FAIL score_sat: %0d required 15", score4); end
    n_checks++;
    if (bird_y !== 10'd0 || game_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ceiling_hold: y=%0d st=%0d required 0 1", bird_y, game_state);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_idle_press();
    test_ticks();
    test_floor();
    test_collide();
    test_async_reset();
    test_ceiling();
    test_score_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
